// File: rtl/cas_fsk_player.sv
// Cassette FSK player: fetches .CAS bytes from the cassette SRAM and plays them
// LSB-first as one square-wave cycle per bit (long half = 0, short half = 1).
module cas_fsk_player #(
    parameter int HALF_ZERO = 23864,
    parameter int HALF_ONE  = 11932,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        COCO_RESET_N,
    input  logic        en,
    input  logic        rewind,
    input  logic [15:0] tape_len,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        casdout,
    output logic        playing,
    output logic        eot
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HIGH,
        S_LOW,
        S_END
    } state_t;

    localparam logic [15:0] LAST_ZERO = 16'(HALF_ZERO - 1);
    localparam logic [15:0] LAST_ONE  = 16'(HALF_ONE - 1);
    localparam logic [1:0]  LAT_LAST  = 2'(RD_LAT);

    state_t      r_state;
    logic [15:0] r_addr;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit;
    logic [15:0] r_cnt;
    logic        r_one;
    logic [1:0]  r_lat;
    logic        r_casdout;
    logic        r_playing;
    logic        r_eot;

    logic [15:0] w_last;
    logic        w_half_done;
    logic [15:0] w_addr_nx;

    // r_one is captured when HIGH is entered so the following LOW uses the same length
    assign w_last      = r_one ? LAST_ONE : LAST_ZERO;
    assign w_half_done = (r_cnt == w_last);
    assign w_addr_nx   = r_addr + 16'd1;

    always_ff @(posedge clk or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_shift   <= '0;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_one     <= 1'b0;
            r_lat     <= '0;
            r_casdout <= 1'b0;
            r_playing <= 1'b0;
            r_eot     <= 1'b0;
        end else if (rewind) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_lat     <= '0;
            r_casdout <= 1'b0;
            r_playing <= 1'b0;
            r_eot     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_lat <= '0;
                        if (r_addr >= tape_len) begin
                            r_state <= S_END;
                            r_eot   <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    // a pause restarts the read latency so rd_data is re-qualified
                    if (!en) begin
                        r_lat <= '0;
                    end else if (r_lat == LAT_LAST) begin
                        r_shift   <= rd_data;
                        r_bit     <= '0;
                        r_one     <= rd_data[0];
                        r_cnt     <= '0;
                        r_casdout <= 1'b1;
                        r_playing <= 1'b1;
                        r_state   <= S_HIGH;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                S_HIGH: begin
                    if (!en) begin
                        r_casdout <= 1'b0;
                        r_playing <= 1'b0;
                    end else begin
                        r_playing <= 1'b1;
                        if (w_half_done) begin
                            r_cnt     <= '0;
                            r_casdout <= 1'b0;
                            r_state   <= S_LOW;
                        end else begin
                            r_cnt     <= r_cnt + 16'd1;
                            r_casdout <= 1'b1;
                        end
                    end
                end
                S_LOW: begin
                    r_casdout <= 1'b0;
                    if (!en) begin
                        r_playing <= 1'b0;
                    end else if (w_half_done) begin
                        r_cnt <= '0;
                        if (r_bit != 3'd7) begin
                            r_shift   <= r_shift >> 1;
                            r_one     <= r_shift[1];
                            r_bit     <= r_bit + 3'd1;
                            r_casdout <= 1'b1;
                            r_playing <= 1'b1;
                            r_state   <= S_HIGH;
                        end else begin
                            r_addr    <= w_addr_nx;
                            r_lat     <= '0;
                            r_playing <= 1'b0;
                            if (w_addr_nx == tape_len) begin
                                r_state <= S_END;
                                r_eot   <= 1'b1;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end else begin
                        r_cnt     <= r_cnt + 16'd1;
                        r_playing <= 1'b1;
                    end
                end
                S_END: begin
                    r_casdout <= 1'b0;
                    r_playing <= 1'b0;
                    r_eot     <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_addr = r_addr;
    assign casdout = r_casdout;
    assign playing = r_playing;
    assign eot     = r_eot;

endmodule

// File: tb/tb_cas_fsk_player.sv
// Directed bench for cas_fsk_player with short half-periods (8/4) and RD_LAT=2.
module tb_cas_fsk_player;

    logic        clk = 1'b0;
    logic        COCO_RESET_N;
    logic        en;
    logic        rewind;
    logic [15:0] tape_len;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        casdout;
    logic        playing;
    logic        eot;

    logic [7:0] mem [0:3];
    logic [7:0] p1, p2;

    int errors = 0;
    int checks = 0;

    cas_fsk_player #(.HALF_ZERO(8), .HALF_ONE(4), .RD_LAT(2)) dut (
        .clk          (clk),
        .COCO_RESET_N (COCO_RESET_N),
        .en           (en),
        .rewind       (rewind),
        .tape_len     (tape_len),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .casdout      (casdout),
        .playing      (playing),
        .eot          (eot)
    );

    always #5 clk = ~clk;

    // two-stage SRAM read pipeline
    always @(posedge clk) begin
        p1 <= mem[rd_addr[1:0]];
        p2 <= p1;
    end
    assign rd_data = p2;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n cycles of casdout expected low
    task automatic gap(input string tag, input int n);
        logic [31:0] obs;
        obs = '0;
        for (int j = 0; j < n; j++) begin
            tick(1);
            obs[j] = casdout;
        end
        check(tag, obs, 32'h0);
    endtask

    // bits lo..hi of byte b: H samples high then H low, playing held high
    task automatic play_byte(input string tag, input logic [7:0] b, input int lo, input int hi);
        logic [31:0] obs, exp;
        int h, pl;
        pl = 0;
        for (int k = lo; k <= hi; k++) begin
            h = b[k] ? 4 : 8;
            obs = '0;
            exp = '0;
            for (int j = 0; j < 2 * h; j++) begin
                tick(1);
                obs[j] = casdout;
                exp[j] = (j < h);
                if (!playing) pl++;
            end
            check($sformatf("%s_bit%0d", tag, k), obs, exp);
        end
        check({tag, "_playing"}, pl, 0);
    endtask

    initial begin
        logic [31:0] v;
        int c0, c1;
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        COCO_RESET_N = 1'b0;
        en = 1'b0;
        rewind = 1'b0;
        tape_len = 16'd0;
        tick(2);
        COCO_RESET_N = 1'b1;
        tick(1);
        check("rst_addr", rd_addr, 0);
        check("rst_casdout", casdout, 0);
        check("rst_playing", playing, 0);
        check("rst_eot", eot, 0);

        // basic byte 0x01
        tape_len = 16'd1;
        en = 1'b1;
        gap("basic_lead", 3);
        play_byte("basic", 8'h01, 0, 7);
        tick(1);
        check("basic_eot", eot, 1);
        check("basic_addr", rd_addr, 1);
        check("basic_end_cas", casdout, 0);

        // multi-byte 0x55, 0xAA
        en = 1'b0; rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
        check("rew_eot", eot, 0);
        check("rew_addr", rd_addr, 0);
        mem[0] = 8'h55; mem[1] = 8'hAA;
        tape_len = 16'd2;
        en = 1'b1;
        gap("multi_lead", 3);
        play_byte("m0", 8'h55, 0, 7);
        tick(1);
        check("multi_gap_addr", rd_addr, 1);
        check("multi_gap0", casdout, 0);
        gap("multi_gap", 2);
        play_byte("m1", 8'hAA, 0, 7);
        tick(1);
        check("multi_eot", eot, 1);
        check("multi_addr", rd_addr, 2);

        // pause inside the first (1-bit) HIGH
        en = 1'b0; rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
        mem[0] = 8'h01;
        tape_len = 16'd1;
        en = 1'b1;
        gap("pause_lead", 3);
        v = '0;
        for (int j = 0; j < 2; j++) begin tick(1); v[j] = casdout; end
        check("pause_pre", v, 32'h3);
        en = 1'b0;
        c0 = 0; c1 = 0;
        for (int j = 0; j < 20; j++) begin
            tick(1);
            if (casdout) c0++;
            if (playing) c1++;
        end
        check("pause_cas", c0, 0);
        check("pause_playing", c1, 0);
        en = 1'b1;
        v = '0;
        for (int j = 0; j < 6; j++) begin tick(1); v[j] = casdout; end
        check("pause_resume", v, 32'h03);
        play_byte("pause", 8'h01, 1, 7);
        tick(1);
        check("pause_eot", eot, 1);

        // rewind during bit 3 of byte 1
        en = 1'b0; rewind = 1'b1;
        tick(1);
        rewind = 1'b0;
        mem[0] = 8'h55; mem[1] = 8'hAA;
        tape_len = 16'd2;
        en = 1'b1;
        gap("rw_lead", 3);
        play_byte("rw0", 8'h55, 0, 7);
        gap("rw_gap", 3);
        play_byte("rw1", 8'hAA, 0, 2);
        tick(2);
        check("rw_mid_cas", casdout, 1);
        rewind = 1'b1;
        tick(1);
        check("rw_addr", rd_addr, 0);
        check("rw_cas", casdout, 0);
        check("rw_playing", playing, 0);
        rewind = 1'b0;
        gap("rw_relead", 3);
        play_byte("rw_replay", 8'h55, 0, 7);

        // async reset in the first HIGH of byte 1
        gap("ar_gap", 3);
        tick(2);
        check("ar_pre_cas", casdout, 1);
        check("ar_pre_addr", rd_addr, 1);
        #2;
        COCO_RESET_N = 1'b0;
        #1;
        check("ar_cas", casdout, 0);
        check("ar_playing", playing, 0);
        check("ar_eot", eot, 0);
        check("ar_addr", rd_addr, 0);
        @(negedge clk);
        en = 1'b0;
        COCO_RESET_N = 1'b1;
        tick(1);

        // zero-length tape
        tape_len = 16'd0;
        en = 1'b1;
        tick(1);
        check("zl_eot", eot, 1);
        check("zl_addr", rd_addr, 0);
        tick(2);
        check("zl_eot_hold", eot, 1);
        check("zl_cas", casdout, 0);
        rewind = 1'b1;
        tick(1);
        check("zl_rew_eot", eot, 0);
        rewind = 1'b0;
        tick(1);
        check("zl_eot_again", eot, 1);
        check("zl_addr_again", rd_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cas_fsk_player.md
# cas_fsk_player

Cassette playback stage that turns a downloaded `.CAS` image, held in the cassette SRAM, into the CoCo's FSK audio bit stream. It sits between the cassette SRAM, which is loaded by `ioctl` with index 2, and the core's `casdout` input, which feeds the PIA cassette comparator and the optional audio monitor. It fetches bytes over a fixed-latency read port and serialises them LSB-first. Each bit is one square-wave cycle: 1200 Hz for a 0 and 2400 Hz for a 1. Playback is gated by the motor relay and reset to the start of the tape by rewind.

## Interface
Parameters
- `HALF_ZERO`, default 23864: clk cycles per half-period of a 0 bit (57.27 MHz / 2400).
- `HALF_ONE`, default 11932: clk cycles per half-period of a 1 bit.
- `RD_LAT`, default 2: cycles from `rd_addr` change to valid `rd_data` (1..3).

Ports
- `clk` in 1: system clock; all logic on the rising edge.
- `COCO_RESET_N` in 1: asynchronous, active-low reset.
- `en` in 1: cassette motor relay; 1 = tape running.
- `rewind` in 1: level; while high, tape held at position 0.
- `tape_len` in 16: number of valid bytes in the image; latched by the loader.
- `rd_addr` out 16: SRAM byte address.
- `rd_data` in 8: SRAM read data, valid `RD_LAT` cycles after `rd_addr`.
- `casdout` out 1: FSK output level.
- `playing` out 1: 1 while in HIGH or LOW state with `en`=1.
- `eot` out 1: end of tape reached; sticky until rewind or reset.

## Operation
- Reset values: `rd_addr`=0, `casdout`=0, `playing`=0, `eot`=0; state IDLE; bit index 0; half counter 0.
- States:
  - **IDLE**: leaves only on `en`=1 and `rewind`=0. Goes to END if `rd_addr` ≥ `tape_len`, otherwise to FETCH.
  - **FETCH**: waits `RD_LAT` cycles, then latches `rd_data` into the shift register, sets bit index to 0, and goes to HIGH.
  - **HIGH**: `casdout`=1 for the half-period selected by shift-register bit 0, then goes to LOW.
  - **LOW**: `casdout`=0 for the same half-period. At the end of LOW:
    - if bit index < 7: shift right, increment the index, go to HIGH;
    - else: increment `rd_addr`; go to END if the new `rd_addr` = `tape_len`, otherwise go to FETCH.
  - **END**: `eot`=1, `casdout`=0. Stays here until rewind.
- Half-period length is chosen from the current bit at entry to HIGH. The same length is used for the LOW that follows.
- Half counter counts 0 to HALF−1 (16-bit). The transition happens on the cycle the counter equals HALF−1, so each half lasts exactly HALF cycles.
- Pause (`en`=0 in FETCH, HIGH or LOW):
  - half counter, bit index, state and `rd_addr` are frozen;
  - `casdout` is forced to 0 and `playing`=0.
  - When `en` returns to 1, the block resumes the same half at the frozen count.
  - A FETCH in progress restarts its latency count on resume.
- Rewind (`rewind`=1, any state): on the next edge, `rd_addr`=0, state=IDLE, `eot`=0, `casdout`=0, counters cleared. Rewind takes priority over `en` and over end-of-byte.
- `tape_len`=0: the first departure from IDLE goes directly to END.
- `tape_len` changing mid-play: it is compared only at byte boundaries. If `rd_addr` > the new length, the END test at the next boundary fails; the FETCH entry test (≥) in IDLE covers resume from IDLE only.

## Timing
- `casdout`, `playing` and `eot` are registered, with no combinational path from inputs.
- Inter-byte gap: one cycle for the LOW→FETCH step plus `RD_LAT` cycles, with `casdout`=0. This is negligible next to the ≥11932-cycle halves.
- `rd_addr` is stable throughout FETCH.
- Latency from `en` rise in IDLE to `casdout`=1 is 2+`RD_LAT` cycles: one for IDLE→FETCH, `RD_LAT` in FETCH, and one to register into HIGH.
- `rewind` and `en` are synchronous to `clk`; the upstream logic is already in the `clk` domain.

## Test plan
Use `HALF_ZERO`=8, `HALF_ONE`=4, `RD_LAT`=2 throughout.
- **Basic byte**: memory[0]=0x01, `tape_len`=1, `en`=1 → `casdout` runs 4 high, 4 low, then seven times 8 high, 8 low. `rd_addr` goes to 1, then `eot`=1 with `casdout`=0.
- **Multi-byte**: memory = 0x55, 0xAA, `tape_len`=2 → bit pattern 1,0,1,0,1,0,1,0 then 0,1,0,1,0,1,0,1. There is a 3-cycle low gap between bytes, `rd_addr` reaches 2, and `eot` rises after the last LOW.
- **Pause**: drop `en` at cycle 2 of a HIGH for 20 cycles → `casdout`=0 and `playing`=0 during the pause. On resume, HIGH continues for the remaining 2 (1-bit) or 6 (0-bit) cycles.
- **Rewind mid-byte**: assert `rewind` during bit 3 of byte 1 → next edge `rd_addr`=0 and `casdout`=0. After release with `en`=1, playback restarts from byte 0, bit 0.
- **Zero-length and end of tape**: `tape_len`=0, `en`=1 → `eot`=1 within 2 cycles and `rd_addr` stays 0. A rewind pulse clears `eot`, which returns to 1 again.
- **Async reset**: assert `COCO_RESET_N`=0 mid-HIGH without a clock edge → `casdout`, `playing`, `eot` and `rd_addr` go to 0 immediately.
